mfu_mac: RTL and testbench
==========================

# mfu_mac

Parametrised precision-scalable multiply-accumulate unit, next generation of the 8-bit fused multiplier. Takes LANES 8-bit operand pairs per beat and computes, per lane, one signed 8x8 product, two signed 4x4 products, or four signed 2x2 products. It sums all lane results, accumulates them over a stream of beats terminated by `in_last`, and emits one result per stream through a valid/ready output. It sits between the operand buffers and the output-channel writeback in the CNN datapath.

## Interface
- `LANES`, 4: number of 8-bit operand lanes per beat; must be ≥ 1.
- `ACC_W`, 32: accumulator/result width; must be ≥ 18 + clog2(LANES).
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  beat present.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
- `in_last`  in  1  final beat of the current accumulation stream.
- `mode`  in  2  per-beat precision: 00 NOOP, 01 8x8, 10 4x4, 11 2x2.
- `a`, `b`  in  8*LANES  signed operands; lane i is bits [8i+7:8i].
- `out_valid`  out  1  result held on `out_data`.
- `out_ready`  in  1  result consumed when `out_valid && out_ready`.
- `out_data`  out  ACC_W  signed accumulated result.
- `out_sat`  out  1  saturation occurred in this stream (see Configuration).

## Operation
- Lane term, all sub-fields two's-complement:
  - 8x8: a[7:0]*b[7:0].
  - 4x4: a[7:4]*b[7:4] + a[3:0]*b[3:0].
  - 2x2: sum over k=0..3 of a[2k+1:2k]*b[2k+1:2k].
  - NOOP: 0.
- Beat term = sum of all lane terms, sign-extended to ACC_W. There is no overflow within a beat, by the ACC_W constraint.
- Stage 1 registers the beat term, a valid flag and the last flag.
- Stage 2 accumulates. The first beat of a stream (after reset or after a last beat) loads `acc <= term`. Later beats do `acc <= acc + term`, which wraps mod 2^ACC_W unless saturation is enabled.
- On a last beat in stage 2:
  - `out_data <= acc_next`, `out_valid <= 1`.
  - The accumulator is marked empty, so the next beat starts a new stream.
- `mode` is sampled per beat. Mixed modes within one stream are legal and sum as defined.
- A NOOP beat counts as a beat. A NOOP last beat still emits a result.
- Stall: `stall = out_valid && !out_ready`.
  - `in_ready = !stall`.
  - While stalled, stage 1, the accumulator and the output register all hold.
- `out_valid` clears on handshake, unless a new result is written in the same cycle. A simultaneous handshake and new result is legal and loads the new result.
- Bubbles (`in_valid=0`) leave the accumulator untouched. Streams may have gaps.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_sat=0`, stage-1 valid 0, accumulator empty. `in_ready=1` from the first cycle after reset.
- Latency: a last beat accepted at edge k produces `out_valid=1` with the result after edge k+1, i.e. visible from the cycle following edge k+1. Throughput is 1 beat/cycle when `out_ready=1`.
- Back-to-back streams (last followed immediately by a new first beat) need no idle cycle.
- `rst` mid-stream discards the partial accumulation, any stage-1 beat and any pending result.
- `in_ready` is combinational from `out_valid`/`out_ready` only. It has no dependency on `in_valid`.

## Configuration
- `MFU_MAC_SATURATE_EN` defined:
  - Each stage-2 addition clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - `out_sat` is 1 for a result if any clamp occurred in that stream, and is sticky until the result is emitted.
- `MFU_MAC_SATURATE_EN` undefined: additions wrap mod 2^ACC_W and `out_sat` is tied 0.

## Test plan
- 8x8, LANES=4, all lanes a=0x80, b=0x80, single last beat -> `out_data`=65536 two cycles after acceptance, `out_sat`=0.
- 4x4, all lanes a=b=0x7F (nibbles 7, -1), last beat -> 200. Then 2x2, all lanes a=b=0xFF, last -> 16, with no idle cycle between the two streams.
- 3-beat stream, 8x8, lane0 a=3 b=5, other lanes 0, bubble between beats 2 and 3 -> 45. Beat 2 in NOOP mode instead -> 30.
- Hold `out_ready=0` after a result while `in_valid=1`:
  - `in_ready`=0, pipeline frozen, `out_data` stable.
  - On release, the held result handshakes and the queued beats resume without loss or duplication.
- ACC_W=20, LANES=4, eight 8x8 beats of all-lane 0x80*0x80 (8×65536=524288):
  - With the macro -> 524287, `out_sat`=1.
  - Without the macro -> -524288, `out_sat`=0.
- Assert `rst` one cycle after the 2nd beat of a 4-beat stream, then send a fresh 1-beat stream of 8x8, lane0 a=2 b=2, others 0 -> `out_valid` stays 0 until that stream's result, which is 4.

Source files
------------

// File: rtl/mfu_mac_if.sv
// mfu_mac_if: beat-in / result-out bundle for the precision-scalable MAC.
//
// Parameters:
//   LANES  number of 8-bit operand lanes per beat
//   ACC_W  accumulator / result width
//
// Signals:
//   in_valid, in_ready, in_last   input beat handshake and end-of-stream flag
//   mode[1:0]                     per-beat precision (00 NOOP, 01 8x8, 10 4x4, 11 2x2)
//   a, b [8*LANES-1:0]            signed operands, lane i at bits [8i+7:8i]
//   out_valid, out_ready          result handshake
//   out_data [ACC_W-1:0]          signed accumulated result
//   out_sat                       a clamp happened somewhere in this stream
//
// Modports: master drives beats and consumes results; slave is the MAC.
interface mfu_mac_if #(
    parameter int LANES = 4,
    parameter int ACC_W = 32
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_last;
    logic [1:0]              mode;
    logic [8*LANES-1:0]      a;
    logic [8*LANES-1:0]      b;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_data;
    logic                    out_sat;

    modport master (
        output in_valid, in_last, mode, a, b, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_last, mode, a, b, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/mfu_mac.sv
// mfu_mac: precision-scalable multiply-accumulate unit.
//
// Each beat carries LANES 8-bit operand pairs. Per lane the unit forms one
// signed 8x8 product, the sum of two signed 4x4 products, or the sum of four
// signed 2x2 products, selected per beat by mode. Lane terms are summed into a
// beat term, which is accumulated over a stream of beats ending with in_last.
// One result per stream leaves through a valid/ready output register.
//
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-high reset
//   bus   mfu_mac_if.slave (beat input, result output)
//
// Pipeline:
//   p1  registered beat term, valid and last flag
//   p2  accumulator and output register
//
// Optional feature: define MFU_MAC_SATURATE_EN to clamp every accumulation
// step to the signed ACC_W range and report clamping on out_sat. Without it
// the accumulator wraps mod 2^ACC_W and out_sat stays 0.
module mfu_mac #(
    parameter int LANES = 4,
    parameter int ACC_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    mfu_mac_if.slave   bus
);
    // Largest lane term is (-128)*(-128) = 16384, so 17 signed bits suffice.
    localparam int LANE_W = 17;
    localparam int SUM_W  = ACC_W + 1;

    function automatic logic signed [LANE_W-1:0] lane_term(
        input logic [7:0] a8,
        input logic [7:0] b8,
        input logic [1:0] md
    );
        logic signed [LANE_W-1:0] t;
        t = '0;
        case (md)
            2'b01: t = LANE_W'($signed(a8)) * LANE_W'($signed(b8));
            2'b10: t = LANE_W'($signed(a8[7:4])) * LANE_W'($signed(b8[7:4]))
                     + LANE_W'($signed(a8[3:0])) * LANE_W'($signed(b8[3:0]));
            2'b11: begin
                for (int k = 0; k < 4; k++) begin
                    t = t + LANE_W'($signed(a8[2*k +: 2])) * LANE_W'($signed(b8[2*k +: 2]));
                end
            end
            default: t = '0;
        endcase
        return t;
    endfunction

`ifdef MFU_MAC_SATURATE_EN
    function automatic logic signed [ACC_W-1:0] acc_add(
        input  logic signed [ACC_W-1:0] x,
        input  logic signed [ACC_W-1:0] y,
        output logic                    ovf
    );
        logic signed [SUM_W-1:0] s;
        s   = SUM_W'(x) + SUM_W'(y);
        // The extra sign bit disagreeing with the result's MSB means overflow.
        ovf = s[ACC_W] ^ s[ACC_W-1];
        if (ovf) begin
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
        return s[ACC_W-1:0];
    endfunction
`else
    function automatic logic signed [ACC_W-1:0] acc_add(
        input  logic signed [ACC_W-1:0] x,
        input  logic signed [ACC_W-1:0] y,
        output logic                    ovf
    );
        ovf = 1'b0;
        return x + y;
    endfunction
`endif

    logic                    stall;
    logic signed [ACC_W-1:0] term_c;

    logic                    vld_p1;
    logic                    last_p1;
    logic signed [ACC_W-1:0] term_p1;

    logic signed [ACC_W-1:0] acc_p2;
    logic                    empty_p2;
    logic                    sat_p2;
    logic                    out_valid_p2;
    logic signed [ACC_W-1:0] out_data_p2;
    logic                    out_sat_p2;

    logic signed [ACC_W-1:0] acc_sum;
    logic                    add_ovf;
    logic signed [ACC_W-1:0] acc_next;
    logic                    sat_next;

    assign stall        = out_valid_p2 && !bus.out_ready;
    assign bus.in_ready = !stall;

    always_comb begin
        term_c = '0;
        for (int l = 0; l < LANES; l++) begin
            term_c = term_c + ACC_W'(lane_term(bus.a[8*l +: 8], bus.b[8*l +: 8], bus.mode));
        end
    end

    // ---- p0 -> p1: register the beat term ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (!stall) begin
            vld_p1 <= bus.in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            term_p1 <= term_c;
            last_p1 <= bus.in_last;
        end
    end

    // An empty accumulator loads the term directly, so a stream's first beat
    // never sees a stale sum and can never clamp.
    always_comb begin
        add_ovf  = 1'b0;
        acc_sum  = acc_add(acc_p2, term_p1, add_ovf);
        acc_next = term_p1;
        sat_next = 1'b0;
        if (!empty_p2) begin
            acc_next = acc_sum;
            sat_next = sat_p2 | add_ovf;
        end
    end

    // ---- p1 -> p2: accumulate and emit ----
    always_ff @(posedge clk) begin
        if (rst) begin
            empty_p2     <= 1'b1;
            sat_p2       <= 1'b0;
            out_valid_p2 <= 1'b0;
            out_data_p2  <= '0;
            out_sat_p2   <= 1'b0;
        end else if (!stall) begin
            // Not stalled means the output is either empty or handshaking now.
            out_valid_p2 <= 1'b0;
            if (vld_p1) begin
                if (last_p1) begin
                    out_valid_p2 <= 1'b1;
                    out_data_p2  <= acc_next;
                    out_sat_p2   <= sat_next;
                    empty_p2     <= 1'b1;
                    sat_p2       <= 1'b0;
                end else begin
                    empty_p2     <= 1'b0;
                    sat_p2       <= sat_next;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!stall && vld_p1 && !last_p1) begin
            acc_p2 <= acc_next;
        end
    end

    assign bus.out_valid = out_valid_p2;
    assign bus.out_data  = out_data_p2;
    assign bus.out_sat   = out_sat_p2;
endmodule

// File: tb/tb_mfu_mac.sv
// Bench for mfu_mac: directed cases plus randomized streams checked against
// a behavioural model that decodes operand fields arithmetically.
module tb_mfu_mac;
    localparam int LANES  = 4;
    localparam int ACC_W  = 32;
    localparam int ACC_W2 = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mfu_mac_if #(.LANES(LANES), .ACC_W(ACC_W)) u_if();
    mfu_mac #(.LANES(LANES), .ACC_W(ACC_W)) u_dut (.clk(clk), .rst(rst), .bus(u_if));

    mfu_mac_if #(.LANES(LANES), .ACC_W(ACC_W2)) u_if2();
    mfu_mac #(.LANES(LANES), .ACC_W(ACC_W2)) u_dut2 (.clk(clk), .rst(rst), .bus(u_if2));

    int     checks   = 0;
    int     failures = 0;
    longint exp_q[$];
    longint got_q[$];
    longint stream_sum = 0;
    int     rdy_force  = 1;   // 0 random, 1 always ready, 2 never ready

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sum of signed sub-field products over all lanes, from the field widths.
    function automatic longint ref_term(input logic [1:0] md, input logic [31:0] av, input logic [31:0] bv);
        int     w;
        longint s, fa, fb;
        s = 0;
        if (md == 2'b00) return 0;
        w = (md == 2'b01) ? 8 : (md == 2'b10) ? 4 : 2;
        for (int l = 0; l < LANES; l++) begin
            for (int k = 0; k < 8 / w; k++) begin
                fa = longint'((av >> (8*l + w*k)) & ((32'd1 << w) - 1));
                fb = longint'((bv >> (8*l + w*k)) & ((32'd1 << w) - 1));
                if (fa >= (longint'(1) << (w-1))) fa -= (longint'(1) << w);
                if (fb >= (longint'(1) << (w-1))) fb -= (longint'(1) << w);
                s += fa * fb;
            end
        end
        return s;
    endfunction

    function automatic longint wrap(input longint v, input int w);
        longint r;
        r = v & ((longint'(1) << w) - 1);
        if (r >= (longint'(1) << (w-1))) r -= (longint'(1) << w);
        return r;
    endfunction

    task automatic send_beat(input logic [1:0] md, input logic [31:0] av, input logic [31:0] bv, input logic lst);
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok) begin
            @(negedge clk);
            u_if.in_valid = 1'b1;
            u_if.mode     = md;
            u_if.a        = av;
            u_if.b        = bv;
            u_if.in_last  = lst;
            #1;
            ok = u_if.in_ready;
            @(posedge clk);
            n++;
            if (!ok && n > 500) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        if (ok) begin
            stream_sum += ref_term(md, av, bv);
            if (lst) begin
                exp_q.push_back(wrap(stream_sum, ACC_W));
                stream_sum = 0;
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        u_if.in_valid = 1'b0;
        u_if.a        = $urandom;
        u_if.b        = $urandom;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || u_if.out_valid) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        #3;
        check(tag, exp_q.size(), 0);
    endtask

    // Called right after the last beat's accepting edge k.
    task automatic expect_latency(input string tag, input longint exp);
        @(negedge clk);
        u_if.in_valid = 1'b0;
        #2;
        check({tag, "_early"}, u_if.out_valid, 0);
        @(negedge clk);
        #2;
        check({tag, "_valid"}, u_if.out_valid, 1);
        check({tag, "_data"}, u_if.out_data, exp);
    endtask

    // Output-ready driver.
    initial begin
        u_if.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (rdy_force)
                0:       u_if.out_ready = ($urandom_range(0, 3) != 0);
                1:       u_if.out_ready = 1'b1;
                default: u_if.out_ready = 1'b0;
            endcase
        end
    end

    // Result monitor and scoreboard.
    initial begin
        bit     prev_stall;
        longint prev_data;
        prev_stall = 1'b0;
        prev_data  = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_stall = 1'b0;
                continue;
            end
            check("in_ready", u_if.in_ready, !(u_if.out_valid && !u_if.out_ready));
            if (prev_stall) check("hold_data", u_if.out_data, prev_data);
            if (u_if.out_valid && u_if.out_ready) begin
                got_q.push_back(u_if.out_data);
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    check("out_data", u_if.out_data, exp_q.pop_front());
                    check("out_sat", u_if.out_sat, 0);
                end
            end
            prev_stall = u_if.out_valid && !u_if.out_ready;
            prev_data  = u_if.out_data;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        longint acc2, s2, max2, min2;
        bit     sat2, seen;
        int     nb;

        rst           = 1'b1;
        u_if.in_valid = 1'b0;
        u_if.in_last  = 1'b0;
        u_if.mode     = 2'b00;
        u_if.a        = '0;
        u_if.b        = '0;
        u_if2.in_valid  = 1'b0;
        u_if2.in_last   = 1'b0;
        u_if2.mode      = 2'b00;
        u_if2.a         = '0;
        u_if2.b         = '0;
        u_if2.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("rst_out_valid", u_if.out_valid, 0);
        check("rst_out_data", u_if.out_data, 0);
        check("rst_out_sat", u_if.out_sat, 0);
        check("rst_in_ready", u_if.in_ready, 1);

        // 8x8 extreme negative operands, with exact latency.
        send_beat(2'b01, 32'h80808080, 32'h80808080, 1'b1);
        expect_latency("t1", 65536);
        wait_drain("t1_drain");

        // 4x4 then 2x2 streams back-to-back.
        got_q.delete();
        send_beat(2'b10, 32'h7f7f7f7f, 32'h7f7f7f7f, 1'b1);
        send_beat(2'b11, 32'hffffffff, 32'hffffffff, 1'b1);
        idle();
        wait_drain("t2_drain");
        check("t2_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("t2_4x4", got_q[0], 200);
            check("t2_2x2", got_q[1], 16);
        end

        // Three beats with a bubble; then the middle beat as NOOP.
        got_q.delete();
        send_beat(2'b01, 32'd3, 32'd5, 1'b0);
        send_beat(2'b01, 32'd3, 32'd5, 1'b0);
        idle();
        send_beat(2'b01, 32'd3, 32'd5, 1'b1);
        send_beat(2'b01, 32'd3, 32'd5, 1'b0);
        send_beat(2'b00, 32'd3, 32'd5, 1'b0);
        idle();
        send_beat(2'b01, 32'd3, 32'd5, 1'b1);
        idle();
        wait_drain("t3_drain");
        check("t3_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("t3_bubble", got_q[0], 45);
            check("t3_noop", got_q[1], 30);
        end

        // Back-pressure: result held while more beats queue up.
        got_q.delete();
        rdy_force = 2;
        send_beat(2'b01, 32'd3, 32'd5, 1'b1);
        send_beat(2'b01, 32'd2, 32'd2, 1'b0);
        fork
            begin
                send_beat(2'b01, 32'd2, 32'd2, 1'b0);
                send_beat(2'b01, 32'd2, 32'd2, 1'b1);
                idle();
            end
            begin
                repeat (4) begin
                    @(negedge clk);
                    #2;
                    check("stall_in_ready", u_if.in_ready, 0);
                    check("stall_out_valid", u_if.out_valid, 1);
                end
                rdy_force = 1;
            end
        join
        wait_drain("t4_drain");
        check("t4_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("t4_first", got_q[0], 15);
            check("t4_second", got_q[1], 12);
        end

        // Reset in the middle of a 4-beat stream.
        got_q.delete();
        send_beat(2'b01, 32'd3, 32'd5, 1'b0);
        send_beat(2'b01, 32'd3, 32'd5, 1'b0);
        @(negedge clk);
        u_if.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        stream_sum = 0;
        #2;
        check("rst2_out_valid", u_if.out_valid, 0);
        check("rst2_in_ready", u_if.in_ready, 1);
        repeat (3) begin
            @(negedge clk);
            #2;
            check("rst2_quiet", u_if.out_valid, 0);
        end
        send_beat(2'b01, 32'd2, 32'd2, 1'b1);
        expect_latency("t5", 4);
        wait_drain("t5_drain");
        check("t5_count", got_q.size(), 1);

        // Randomized streams with bubbles and random back-pressure.
        rdy_force = 0;
        for (int s = 0; s < 40; s++) begin
            nb = $urandom_range(1, 5);
            for (int i = 0; i < nb; i++) begin
                if ($urandom_range(0, 3) == 0) idle();
                send_beat(2'(($urandom_range(0, 3))), $urandom, $urandom, (i == nb - 1));
            end
        end
        idle();
        rdy_force = 1;
        wait_drain("rand_drain");

        // Narrow accumulator: eight maximal 8x8 beats overflow 20 bits.
        max2 = (longint'(1) << (ACC_W2 - 1)) - 1;
        min2 = -(longint'(1) << (ACC_W2 - 1));
        acc2 = 0;
        sat2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s2 = ref_term(2'b01, 32'h80808080, 32'h80808080);
            if (i != 0) begin
                s2 = acc2 + s2;
`ifdef MFU_MAC_SATURATE_EN
                if (s2 > max2) begin s2 = max2; sat2 = 1'b1; end
                if (s2 < min2) begin s2 = min2; sat2 = 1'b1; end
`else
                s2 = wrap(s2, ACC_W2);
`endif
            end
            acc2 = s2;
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            u_if2.in_valid = 1'b1;
            u_if2.mode     = 2'b01;
            u_if2.a        = 32'h80808080;
            u_if2.b        = 32'h80808080;
            u_if2.in_last  = (i == 7);
        end
        @(negedge clk);
        u_if2.in_valid = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            #2;
            if (u_if2.out_valid) seen = 1'b1;
            else @(negedge clk);
        end
        check("sat_seen", seen, 1);
        check("sat_data", u_if2.out_data, acc2);
        check("sat_flag", u_if2.out_sat, sat2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
